led_show_controller: RTL and testbench
======================================

# led_show_controller

Sequencer for the 8-LED front panel: runs one of three display patterns (bouncing scan, bar fill, alternating blink) at a selectable step rate and accepts start/stop/next/hold commands. It owns the step-rate divider and pattern registers and drives `led` directly. In auto mode it cycles through the patterns on its own. It sits between the board's debounced button and switch logic and the LED pins, on the 16 MHz system clock.

## Interface
- `BASE_DIV`, default 2_000_000: step period in clk cycles at `spd`=0 (125 ms at 16 MHz). Must be a multiple of 8 and ≥ 8.
- `STEPS_PER_MODE`, default 28: steps per pattern before an auto-advance. Range 1..255.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: one-cycle pulse, begins display.
- `stop`  in  1: one-cycle pulse, blanks the LEDs and goes idle.
- `next`  in  1: one-cycle pulse, selects the next pattern.
- `hold`  in  1: level; freezes the display while high.
- `auto`  in  1: level; enables auto-advance.
- `spd`  in  2: step-rate select; period = `BASE_DIV >> spd`.
- `led`  out  8: LED drive, registered.
- `mode`  out  2: current pattern; SCAN=0, FILL=1, BLINK=2. Value 3 is never produced.
- `running`  out  1: high in RUN and HOLD.
- `step_tick`  out  1: one-cycle pulse on each pattern step.

## Operation
- FSM states:
  - IDLE: `led`=0.
  - RUN: pattern steps on each divider wrap.
  - HOLD: `led`, divider and step count frozen.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→HOLD while `hold`=1.
  - HOLD→RUN when `hold`=0; the divider resumes from its frozen value.
  - Any state→IDLE on `stop`.
- Command priority: `stop` > `start` > `next`.
  - `start` in RUN or HOLD restarts the current pattern from its initial value.
  - `next` in IDLE changes `mode` only; the state stays IDLE.
- Pattern entry clears the divider, step count and pattern register, then loads the initial value. Entry happens on `start`, on `next`, and on auto-advance.
- Patterns:
  - SCAN: 0x01, 0x02 … 0x80, 0x40 … 0x01, 0x02 …; 14-step period. Direction flips on the same step that reaches an end, so no end value repeats.
  - FILL: `led` = (1<<n)−1, with n running 0→8→0→1…; 16-step period; initial n=0.
  - BLINK: 0x55, 0xAA alternating; initial 0x55.
- Auto-advance: when `auto`=1 and the step count reaches `STEPS_PER_MODE`, the next step tick enters the next mode instead of stepping. Order: SCAN→FILL→BLINK→SCAN.
- `next` coinciding with an auto-advance tick produces exactly one advance.
- `spd` is sampled only at divider wrap or pattern entry; a change never truncates the current period.

## Timing
- Reset values: `led`=0, `mode`=0, `running`=0, `step_tick`=0, state IDLE, divider=0, step count=0.
- `start` sampled at cycle t: at t+1 `running`=1 and `led` shows the initial pattern value.
- First `step_tick`:
  - It is asserted at t+P, where P=`BASE_DIV>>spd`.
  - The new `led` value is visible in the same cycle as `step_tick`.
  - Subsequent ticks follow every P cycles while in RUN.
- `stop` at t: `led`=0 and `running`=0 at t+1.
- `hold` rise at t: no `step_tick` from t+1 onward.
- `hold` cycle accounting: RUN cycles before and after a hold together equal P per step.
- `next` at t: `mode` updated and `led` at the new initial value at t+1.

## Configuration
- `LED_SHOW_TRAIL_EN` defined: in SCAN only, the previous head position is also lit at 25% duty.
  - Duty comes from a free-running 2-bit PWM counter; the trail LED is on when the counter is 0.
  - The previous position is cleared to none on pattern entry.
  - FILL and BLINK are unaffected.
- Not defined: `led` equals the pattern register exactly, and no PWM logic exists.

## Structure
- Package `led_show_pkg` holds:
  - mode enum (SCAN/FILL/BLINK) and FSM state enum;
  - initial-value constants 8'h01, 8'h00, 8'h55 and BLINK alternate 8'hAA;
  - SCAN period 14 and FILL period 16.
- Sub-module `led_step_timer`:
  - Contains the divider with `spd` sampling, freeze (hold) and clear (entry) inputs, and a wrap pulse output.
  - Counter width: $clog2(BASE_DIV).

## Test plan
- `BASE_DIV`=8, `spd`=0, `start`: `led` goes 0x01 at t+1, then steps every 8 cycles through 0x02…0x80, 0x40…0x01, 0x02; no value is repeated at the ends.
- Auto on, `STEPS_PER_MODE`=4: after 4 SCAN steps, `mode`=1 and `led`=0x00; after 4 FILL steps, BLINK at 0x55.
- `next` asserted on the same cycle as an auto-advance tick: `mode` advances by exactly one.
- `spd`=3 with `BASE_DIV`=32: ticks every 4 cycles. Switching to `spd`=0 mid-period: the current 4-cycle period completes, then ticks every 32 cycles.
- `hold` high for 100 cycles mid-period: `led` is constant. After release, the tick arrives at the remaining count; total RUN cycles equal P.
- `stop` and `start` on the same cycle during RUN: IDLE, `led`=0, `running`=0 at the next cycle.

Source files
------------

// File: rtl/led_show_pkg.sv
// Shared types, constants and pattern helpers for the LED show sequencer.
package led_show_pkg;

    typedef enum logic [1:0] {
        ModeScan  = 2'd0,
        ModeFill  = 2'd1,
        ModeBlink = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

    localparam logic [7:0] ScanInit  = 8'h01;
    localparam logic [7:0] FillInit  = 8'h00;
    localparam logic [7:0] BlinkInit = 8'h55;
    localparam logic [7:0] BlinkAlt  = 8'hAA;

    localparam int unsigned ScanPeriod = 14;
    localparam int unsigned FillPeriod = 16;

    // Pattern register plus direction bit (0 = growing/left, 1 = shrinking/right).
    typedef struct packed {
        logic [7:0] pat;
        logic       dir;
    } pat_t;

    function automatic mode_e next_mode(mode_e m);
        case (m)
            ModeScan: return ModeFill;
            ModeFill: return ModeBlink;
            default:  return ModeScan;
        endcase
    endfunction

    function automatic logic [7:0] init_value(mode_e m);
        case (m)
            ModeScan: return ScanInit;
            ModeFill: return FillInit;
            default:  return BlinkInit;
        endcase
    endfunction

    // One pattern step; direction flips on the step that lands on an end value.
    function automatic pat_t step_pattern(mode_e m, pat_t cur);
        pat_t nxt;
        nxt = cur;
        case (m)
            ModeScan: begin
                nxt.pat = cur.dir ? (cur.pat >> 1) : (cur.pat << 1);
                if (nxt.pat == 8'h80 || nxt.pat == 8'h01) nxt.dir = ~cur.dir;
            end
            ModeFill: begin
                nxt.pat = cur.dir ? (cur.pat >> 1) : {cur.pat[6:0], 1'b1};
                if (nxt.pat == 8'hFF || nxt.pat == 8'h00) nxt.dir = ~cur.dir;
            end
            default: begin
                nxt.pat = (cur.pat == BlinkInit) ? BlinkAlt : BlinkInit;
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/led_show_if.sv
// Command/status bundle between the panel button logic and the LED sequencer.
interface led_show_if;
    import led_show_pkg::*;

    logic       start;
    logic       stop;
    logic       next;
    logic       hold;
    logic       auto;
    logic [1:0] spd;
    logic [7:0] led;
    mode_e      mode;
    logic       running;
    logic       step_tick;

    modport master (
        output start, stop, next, hold, auto, spd,
        input  led, mode, running, step_tick
    );

    modport slave (
        input  start, stop, next, hold, auto, spd,
        output led, mode, running, step_tick
    );

endinterface

// File: rtl/led_step_timer.sv
// Step-rate divider: period BASE_DIV >> spd, spd latched only at wrap or restart.
module led_step_timer #(
    parameter int unsigned BASE_DIV = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] spd,
    input  logic       en,       // counts only while high (hold freezes it)
    input  logic       restart,  // pattern entry from a command
    output logic       wrap
);
    localparam int unsigned W = $clog2(BASE_DIV);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] lim_q, lim_d;
    logic [W-1:0] lim_sel;

    assign lim_sel = W'((BASE_DIV >> spd) - 1);
    assign wrap    = en && (cnt_q >= lim_q);

    // Next count and latched period limit.
    always_comb begin
        cnt_d = cnt_q;
        lim_d = lim_q;
        if (restart) begin
            // The command cycle itself is the first cycle of the new period.
            cnt_d = W'(1);
            lim_d = lim_sel;
        end else if (wrap) begin
            cnt_d = '0;
            lim_d = lim_sel;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            lim_q <= W'(BASE_DIV - 1);
        end else begin
            cnt_q <= cnt_d;
            lim_q <= lim_d;
        end
    end

endmodule

// File: rtl/led_show_controller.sv
// LED front-panel sequencer: SCAN / FILL / BLINK patterns with start/stop/next/hold.
// Optional build macro LED_SHOW_TRAIL_EN adds a 25% duty trail behind the SCAN head.
module led_show_controller
    import led_show_pkg::*;
#(
    parameter int unsigned BASE_DIV       = 2_000_000,
    parameter int unsigned STEPS_PER_MODE = 28
) (
    input logic       clk,
    input logic       rst,
    led_show_if.slave bus
);
    state_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    pat_t       pat_q, pat_d;
    logic [7:0] steps_q, steps_d;
    logic       tick_q, tick_d;
    logic       enter;
    logic       en, restart, wrap;

    assign en      = (state_q == StRun) && !bus.hold;
    assign restart = !bus.stop && (bus.start || (bus.next && state_q != StIdle));

    led_step_timer #(
        .BASE_DIV(BASE_DIV)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .spd    (bus.spd),
        .en     (en),
        .restart(restart),
        .wrap   (wrap)
    );

    // Command decode (stop > start > next), stepping and auto-advance.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pat_d   = pat_q;
        steps_d = steps_q;
        tick_d  = 1'b0;
        enter   = 1'b0;
        if (bus.stop) begin
            state_d = StIdle;
            pat_d   = '0;
        end else if (bus.start) begin
            state_d = StRun;
            enter   = 1'b1;
        end else if (bus.next) begin
            mode_d = next_mode(mode_q);
            enter  = (state_q != StIdle);
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.hold) begin
                        state_d = StHold;
                    end else if (wrap) begin
                        tick_d = 1'b1;
                        if (bus.auto && steps_q >= 8'(STEPS_PER_MODE)) begin
                            mode_d = next_mode(mode_q);
                            enter  = 1'b1;
                        end else begin
                            pat_d = step_pattern(mode_q, pat_q);
                            if (steps_q != 8'hFF) steps_d = steps_q + 8'd1;
                        end
                    end
                end
                StHold: begin
                    if (!bus.hold) state_d = StRun;
                end
                default: ;
            endcase
        end
        if (enter) begin
            pat_d.pat = init_value(mode_d);
            pat_d.dir = 1'b0;
            steps_d   = '0;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= ModeScan;
            pat_q   <= '0;
            steps_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pat_q   <= pat_d;
            steps_q <= steps_d;
            tick_q  <= tick_d;
        end
    end

`ifdef LED_SHOW_TRAIL_EN
    logic [1:0] pwm_q, pwm_d;
    logic [7:0] trail_q, trail_d;
    logic [7:0] led_q;
    logic       stepped;

    assign stepped = tick_d && !enter;
    assign pwm_d   = pwm_q + 2'd1;

    // Previous SCAN head; forgotten on pattern entry and stop.
    always_comb begin
        trail_d = trail_q;
        if (bus.stop || enter) begin
            trail_d = '0;
        end else if (stepped && mode_q == ModeScan) begin
            trail_d = pat_q.pat;
        end
    end

    // PWM counter, trail register and registered LED drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q   <= '0;
            trail_q <= '0;
            led_q   <= '0;
        end else begin
            pwm_q   <= pwm_d;
            trail_q <= trail_d;
            led_q   <= pat_d.pat |
                       ((mode_d == ModeScan && pwm_d == 2'd0) ? trail_d : 8'h00);
        end
    end

    assign bus.led = led_q;
`else
    assign bus.led = pat_q.pat;
`endif

    assign bus.mode      = mode_q;
    assign bus.running   = (state_q != StIdle);
    assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_led_show_controller.sv
// Scoreboard bench for led_show_controller against a cycle-level behavioural model.
module tb_led_show_controller;
    localparam int unsigned BaseDiv      = 32;
    localparam int unsigned StepsPerMode = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_show_if bus ();

    led_show_controller #(
        .BASE_DIV      (BaseDiv),
        .STEPS_PER_MODE(StepsPerMode)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] led;
        logic [1:0] mode;
        logic       running;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic       s_rst = 1'b1;
    logic       s_start = 1'b0, s_stop = 1'b0, s_next = 1'b0, s_hold = 1'b0, s_auto = 1'b0;
    logic [1:0] s_spd = 2'd0;

    // Model state: 0 idle, 1 run, 2 hold; pattern tracked as phase within its period.
    int m_state, m_mode, m_phase, m_steps, m_rem;

    function automatic int period(logic [1:0] spd);
        return int'(BaseDiv >> spd);
    endfunction

    function automatic int plen(int mode);
        return (mode == 0) ? 14 : (mode == 1) ? 16 : 2;
    endfunction

    function automatic logic [7:0] pattern(int mode, int phase);
        int pos;
        int n;
        case (mode)
            0: begin
                pos = (phase < 8) ? phase : 14 - phase;
                return 8'(1 << pos);
            end
            1: begin
                n = (phase <= 8) ? phase : 16 - phase;
                return 8'((1 << n) - 1);
            end
            default: return (phase % 2 == 0) ? 8'h55 : 8'hAA;
        endcase
    endfunction

    task automatic enter_pattern();
        m_phase = 0;
        m_steps = 0;
        m_rem   = period(s_spd) - 1;  // command cycle counts toward the first period
    endtask

    task automatic model_step(output logic tick);
        tick = 1'b0;
        if (s_rst) begin
            m_state = 0; m_mode = 0; m_phase = 0; m_steps = 0; m_rem = 0;
        end else if (s_stop) begin
            m_state = 0;
        end else if (s_start) begin
            m_state = 1;
            enter_pattern();
        end else if (s_next) begin
            m_mode = (m_mode + 1) % 3;
            if (m_state != 0) enter_pattern();
        end else if (m_state == 1) begin
            if (s_hold) begin
                m_state = 2;
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    tick  = 1'b1;
                    m_rem = period(s_spd);
                    if (s_auto && m_steps >= int'(StepsPerMode)) begin
                        m_mode  = (m_mode + 1) % 3;
                        m_phase = 0;
                        m_steps = 0;
                    end else begin
                        m_phase = (m_phase + 1) % plen(m_mode);
                        if (m_steps < 255) m_steps++;
                    end
                end
            end
        end else if (m_state == 2 && !s_hold) begin
            m_state = 1;
        end
    endtask

    // Drive one cycle of stimulus, advance the model and queue the expected outputs.
    task automatic cycle();
        logic t;
        exp_t e;
        @(negedge clk);
        rst       = s_rst;
        bus.start = s_start;
        bus.stop  = s_stop;
        bus.next  = s_next;
        bus.hold  = s_hold;
        bus.auto  = s_auto;
        bus.spd   = s_spd;
        model_step(t);
        e.led     = (m_state == 0) ? 8'h00 : pattern(m_mode, m_phase);
        e.mode    = 2'(m_mode);
        e.running = (m_state != 0);
        e.tick    = t;
        exp_q.push_back(e);
        s_start = 1'b0;
        s_stop  = 1'b0;
        s_next  = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Monitor: the DUT presents a full output word every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (bus.led !== e.led || 2'(bus.mode) !== e.mode ||
                    bus.running !== e.running || bus.step_tick !== e.tick) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got led=%h mode=%0d running=%b tick=%b, want led=%h mode=%0d running=%b tick=%b",
                             $time, bus.led, bus.mode, bus.running, bus.step_tick,
                             e.led, e.mode, e.running, e.tick);
                end
            end
        end
    end

    initial begin
        bit done;
        bus.start = 1'b0; bus.stop = 1'b0; bus.next = 1'b0;
        bus.hold = 1'b0; bus.auto = 1'b0; bus.spd = 2'd0;

        // Reset.
        s_rst = 1'b1;
        run(3);
        s_rst = 1'b0;
        run(2);

        // next in IDLE changes mode only, then back to SCAN.
        s_next = 1'b1; cycle();
        s_next = 1'b1; cycle();
        s_next = 1'b1; cycle();

        // SCAN at P=8 through both ends.
        s_spd = 2'd2;
        s_start = 1'b1; cycle();
        run(130);

        // Auto-advance through FILL and BLINK.
        s_auto = 1'b1;
        s_start = 1'b1; cycle();
        run(140);

        // next exactly on an auto-advance tick.
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (m_state == 1 && m_rem == 1 && m_steps >= int'(StepsPerMode)) begin
                s_next = 1'b1;
                done   = 1'b1;
            end
            cycle();
        end
        run(20);
        s_auto = 1'b0;

        // spd=3 (P=4), switch to spd=0 mid-period.
        s_spd = 2'd3;
        s_start = 1'b1; cycle();
        run(9);
        s_spd = 2'd0;
        run(80);

        // Hold for 100 cycles mid-period.
        s_spd = 2'd2;
        s_start = 1'b1; cycle();
        run(3);
        s_hold = 1'b1; run(100);
        s_hold = 1'b0; run(30);

        // stop and start together while running.
        s_stop = 1'b1; s_start = 1'b1; cycle();
        run(10);

        // Randomized traffic.
        s_start = 1'b1; cycle();
        for (int i = 0; i < 4000; i++) begin
            s_start = ($urandom_range(0, 63) == 0);
            s_stop  = ($urandom_range(0, 149) == 0);
            s_next  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 79) == 0) s_hold = ~s_hold;
            if ($urandom_range(0, 199) == 0) s_auto = ~s_auto;
            if ($urandom_range(0, 99) == 0) s_spd = 2'($urandom_range(0, 3));
            cycle();
        end

        @(posedge clk);
        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
